// File: rtl/idct_odd_mac32.sv
// 32-point IDCT odd part: takes y1,y3..y31 serially, accumulates them against the
// transposed odd matrix using shift-add products, and presents b0..b15 in parallel.
// state  | meaning
// S_ACC  | accepting coefficients, accumulating 16 columns
// S_DONE | frame complete, b_out held until downstream takes it
module idct_odd_mac32 #(
  parameter int IN_W  = 19,
  parameter int SHIFT = 7,
  parameter int OUT_W = 19
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] coef_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(OUT_W<<4)-1:0]  b_out
);
  localparam int ACC_W = IN_W + 11;
  localparam int RND   = (1 << SHIFT) >> 1;

  typedef enum logic {S_ACC, S_DONE} state_t;
  typedef logic [15:0][4:0] row_t;

  localparam logic [15:0][6:0] ODD = {7'd4,  7'd13, 7'd22, 7'd31, 7'd38, 7'd46, 7'd54, 7'd61,
                                      7'd67, 7'd73, 7'd78, 7'd82, 7'd85, 7'd88, 7'd90, 7'd90};

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // {negate, ODD index} for each k of column n; the phase p advances by 2(2n+1) mod 128.
  function automatic row_t row_code(input int n);
    row_t r;
    int   p;
    int   step;
    r    = '0;
    p    = (n << 1) + 1;
    step = (n << 2) + 2;
    for (int k = 0; k < 16; k++) begin
      if (p < 32)      r[k] = {1'b0, 4'((p - 1) >> 1)};
      else if (p < 64) r[k] = {1'b1, 4'((63 - p) >> 1)};
      else if (p < 96) r[k] = {1'b1, 4'((p - 65) >> 1)};
      else             r[k] = {1'b0, 4'((127 - p) >> 1)};
      p = (p + step) & 127;
    end
    return r;
  endfunction

  function automatic logic signed [ACC_W-1:0] mul_const(input logic signed [ACC_W-1:0] x,
                                                        input logic [6:0] c);
    logic signed [ACC_W-1:0] r;
    r = '0;
    for (int b = 0; b < 7; b++) begin
      if (c[b]) r = r + (x <<< b);
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] s;
    logic [OUT_W-1:0]      r;
    s = ($signed({a[ACC_W-1], a}) + $signed((ACC_W+1)'(RND))) >>> SHIFT;
    if (s > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = s[OUT_W-1:0];
    return r;
  endfunction

  state_t                     state_q, state_d;
  logic [3:0]                 k_q, k_d;
  logic signed [ACC_W-1:0]    acc_q [16];
  logic signed [ACC_W-1:0]    acc_d [16];
  logic [15:0][OUT_W-1:0]     bout_q, bout_d;

  logic signed [ACC_W-1:0]    coef_ext;
  logic signed [ACC_W-1:0]    prod [16];
  logic signed [ACC_W-1:0]    term [16];

  assign coef_ext = {{(ACC_W-IN_W){coef_in[IN_W-1]}}, coef_in};

  // One shared product per distinct matrix magnitude; columns only select and negate.
  for (genvar j = 0; j < 16; j++) begin : g_prod
    assign prod[j] = mul_const(coef_ext, ODD[j]);
  end

  for (genvar n = 0; n < 16; n++) begin : g_col
    localparam row_t ROW = row_code(n);
    logic [4:0] sel;
    assign sel     = ROW[k_q];
    assign term[n] = sel[4] ? -prod[sel[3:0]] : prod[sel[3:0]];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_ACC;
      k_q     <= '0;
      bout_q  <= '0;
      for (int n = 0; n < 16; n++) acc_q[n] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bout_q  <= bout_d;
      for (int n = 0; n < 16; n++) acc_q[n] <= acc_d[n];
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bout_d    = bout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    for (int n = 0; n < 16; n++) acc_d[n] = acc_q[n];
    case (state_q)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int n = 0; n < 16; n++) acc_d[n] = acc_q[n] + term[n];
          k_d = k_q + 4'd1;
          if (k_q == 4'd15) begin
            state_d = S_DONE;
            for (int n = 0; n < 16; n++) bout_d[n] = round_sat(acc_d[n]);
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          for (int n = 0; n < 16; n++) acc_d[n] = '0;
          k_d     = '0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  assign b_out = bout_q;

endmodule
